// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch
//  Description : Fetch-PC owner with a direct-mapped, one-word-per-line
//                instruction cache; refills from memory on a miss and pushes
//                {instr, pc} to the IF queue, one per cycle.
//                Optional hit/miss counters: define ICACHE_STAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch #(
    parameter int LINES = 64,
    parameter int IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_not_full,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in,
    output logic        have_out,
    output logic [31:0] instr_out,
`ifdef ICACHE_STAT_EN
    output logic [31:0] hit_cnt_out,
    output logic [31:0] miss_cnt_out,
`endif
    output logic [31:0] instr_pc_out
);

    localparam int c_TAG_W = 32 - IDX_W - 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [LINES-1:0]     r_valid;
    logic [c_TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]          r_data [LINES];
    logic [IDX_W-1:0]     r_miss_idx;
    logic [c_TAG_W-1:0]   r_miss_tag;

    logic [IDX_W-1:0]     w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_fill;

    assign w_idx  = r_pc[IDX_W+1:2];
    assign w_tag  = r_pc[31:IDX_W+2];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = rdy_in && (r_state == S_MISS) && mem_done_in;

    // Line storage carries no reset; the valid vector alone gates hits.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_data[r_miss_idx] <= mem_data_in;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_pc         <= 32'd0;
            r_valid      <= '0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
            mem_req_out  <= 1'b0;
            mem_addr_out <= 32'd0;
            have_out     <= 1'b0;
            instr_out    <= 32'd0;
            instr_pc_out <= 32'd0;
`ifdef ICACHE_STAT_EN
            hit_cnt_out  <= 32'd0;
            miss_cnt_out <= 32'd0;
`endif
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        have_out <= 1'b0;
                    end else if (!if_not_full) begin
                        have_out <= 1'b0;
                    end else if (w_hit) begin
                        have_out     <= 1'b1;
                        instr_out    <= r_data[w_idx];
                        instr_pc_out <= r_pc;
                        r_pc         <= r_pc + 32'd4;
`ifdef ICACHE_STAT_EN
                        hit_cnt_out  <= hit_cnt_out + 32'd1;
`endif
                    end else begin
                        have_out     <= 1'b0;
                        mem_req_out  <= 1'b1;
                        mem_addr_out <= {r_pc[31:2], 2'b00};
                        r_miss_idx   <= w_idx;
                        r_miss_tag   <= w_tag;
                        r_state      <= S_MISS;
`ifdef ICACHE_STAT_EN
                        miss_cnt_out <= miss_cnt_out + 32'd1;
`endif
                    end
                end
                S_MISS: begin
                    // An outstanding request always completes; a redirect only moves the PC.
                    have_out <= 1'b0;
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (mem_done_in) begin
                        r_valid[r_miss_idx] <= 1'b1;
                        mem_req_out         <= 1'b0;
                        r_state             <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_fetch
//  Description : Directed self-checking bench for icache_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_not_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done_in;
    logic [31:0] mem_data_in;
    logic        have_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    icache_fetch #(.LINES(64), .IDX_W(6)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_not_full    (if_not_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_done_in    (mem_done_in),
        .mem_data_in    (mem_data_in),
        .have_out       (have_out),
        .instr_out      (instr_out),
`ifdef ICACHE_STAT_EN
        .hit_cnt_out    (hit_cnt),
        .miss_cnt_out   (miss_cnt),
`endif
        .instr_pc_out   (instr_pc_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Memory image returned by the bench's memory model.
    function automatic logic [31:0] exp_instr(input logic [31:0] addr);
        return (addr == 32'd0) ? 32'h0000_0013 : (32'hA000_0000 | addr);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Waits (bounded) for a request, then answers it with a one-cycle done pulse.
    task automatic serve(output bit found, output logic [31:0] got);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req_out === 1'b1) found = 1'b1;
            else tick();
        end
        got = mem_addr_out;
        if (found) begin
            mem_done_in = 1'b1;
            mem_data_in = exp_instr(got);
            tick();
            mem_done_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (have_out !== 1'b0) begin bad++; $display("FAIL reset_have got=%0h want=0", have_out); end
        total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h want=0", mem_req_out); end
        total++; if (mem_addr_out !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr_out); end
        total++; if (instr_out !== 32'd0 || instr_pc_out !== 32'd0) begin
            bad++; $display("FAIL reset_instr got=%h/%h want=0/0", instr_out, instr_pc_out);
        end
    endtask

    task automatic test_cold_start();
        rst_in = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0) begin
            bad++; $display("FAIL cold_req got=%0h addr=%h want=1 addr=0", mem_req_out, mem_addr_out);
        end
        tick();
        tick();
        mem_done_in = 1'b1;
        mem_data_in = 32'h0000_0013;
        tick();
        mem_done_in = 1'b0;
        total++; if (mem_req_out !== 1'b0 || have_out !== 1'b0) begin
            bad++; $display("FAIL cold_done got req=%0h have=%0h want 0/0", mem_req_out, have_out);
        end
        tick();
        total++; if (have_out !== 1'b1 || instr_out !== 32'h13 || instr_pc_out !== 32'h0) begin
            bad++; $display("FAIL cold_hit got have=%0h instr=%h pc=%h want 1/00000013/0", have_out, instr_out, instr_pc_out);
        end
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h4 || have_out !== 1'b0) begin
            bad++; $display("FAIL cold_next got req=%0h addr=%h have=%0h want 1/4/0", mem_req_out, mem_addr_out, have_out);
        end
    endtask

    task automatic test_hit_stream();
        bit          found;
        logic [31:0] got;
        for (int a = 4; a <= 32'h1C; a += 4) begin
            serve(found, got);
            total++; if (!found || got !== 32'(a)) begin
                bad++; $display("FAIL fill_addr got found=%0d addr=%h want %h", found, got, a);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        total++; if (have_out !== 1'b0) begin bad++; $display("FAIL redirect_have got=%0h want=0", have_out); end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (have_out !== 1'b1 || instr_pc_out !== 32'(4 * k) || instr_out !== exp_instr(32'(4 * k))
                         || mem_req_out !== 1'b0) begin
                bad++; $display("FAIL stream got have=%0h pc=%h instr=%h req=%0h want pc=%h instr=%h",
                                have_out, instr_pc_out, instr_out, mem_req_out, 4 * k, exp_instr(32'(4 * k)));
            end
        end
    endtask

    task automatic test_backpressure();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        total++; if (have_out !== 1'b1 || instr_pc_out !== 32'h8) begin
            bad++; $display("FAIL bp_pre got have=%0h pc=%h want 1/8", have_out, instr_pc_out);
        end
        if_not_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (have_out !== 1'b0 || mem_req_out !== 1'b0) begin
                bad++; $display("FAIL bp_hold got have=%0h req=%0h want 0/0", have_out, mem_req_out);
            end
        end
        if_not_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (have_out !== 1'b1 || instr_pc_out !== 32'(12 + 4 * k)) begin
                bad++; $display("FAIL bp_resume got have=%0h pc=%h want 1/%h", have_out, instr_pc_out, 12 + 4 * k);
            end
        end
    endtask

    task automatic test_redirect_in_miss();
        bit          found;
        logic [31:0] got;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h40) begin
            bad++; $display("FAIL rim_req got req=%0h addr=%h want 1/40", mem_req_out, mem_addr_out);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h40 || have_out !== 1'b0) begin
            bad++; $display("FAIL rim_hold got req=%0h addr=%h have=%0h want 1/40/0", mem_req_out, mem_addr_out, have_out);
        end
        mem_done_in = 1'b1;
        mem_data_in = exp_instr(32'h40);
        tick();
        mem_done_in = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h100 || have_out !== 1'b0) begin
            bad++; $display("FAIL rim_next got req=%0h addr=%h have=%0h want 1/100/0", mem_req_out, mem_addr_out, have_out);
        end
        serve(found, got);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (have_out !== 1'b1 || instr_pc_out !== 32'h40 || instr_out !== exp_instr(32'h40)) begin
            bad++; $display("FAIL rim_line40 got have=%0h pc=%h instr=%h want 1/40/%h", have_out, instr_pc_out, instr_out, exp_instr(32'h40));
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_conflict();
        bit          found;
        logic [31:0] got;
        logic [31:0] a;
`ifdef ICACHE_STAT_EN
        logic [31:0] h0 = hit_cnt;
        logic [31:0] m0 = miss_cnt;
`endif
        for (int k = 0; k < 4; k++) begin
            a = (k % 2 == 0) ? 32'h0 : 32'h100;
            redirect_valid = 1'b1;
            redirect_pc    = a;
            tick();
            redirect_valid = 1'b0;
            serve(found, got);
            total++; if (!found || got !== a) begin
                bad++; $display("FAIL conflict_miss got found=%0d addr=%h want %h", found, got, a);
            end
        end
`ifdef ICACHE_STAT_EN
        total++; if (miss_cnt !== m0 + 32'd4 || hit_cnt !== h0) begin
            bad++; $display("FAIL conflict_stats got miss=%0d hit=%0d want %0d/%0d", miss_cnt, hit_cnt, m0 + 4, h0);
        end
`endif
    endtask

    task automatic test_rdy_and_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h200) begin
            bad++; $display("FAIL rdy_pre got req=%0h addr=%h want 1/200", mem_req_out, mem_addr_out);
        end
        rdy_in      = 1'b0;
        mem_done_in = 1'b1;
        mem_data_in = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h200 || have_out !== 1'b0) begin
                bad++; $display("FAIL rdy_freeze got req=%0h addr=%h have=%0h want 1/200/0", mem_req_out, mem_addr_out, have_out);
            end
        end
        rdy_in      = 1'b1;
        mem_done_in = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h200) begin
            bad++; $display("FAIL rdy_after got req=%0h addr=%h want 1/200", mem_req_out, mem_addr_out);
        end
        #2 rst_in = 1'b1;
        #1;
        total++; if (mem_req_out !== 1'b0 || mem_addr_out !== 32'h0 || have_out !== 1'b0
                     || instr_out !== 32'h0 || instr_pc_out !== 32'h0) begin
            bad++; $display("FAIL async_reset got req=%0h addr=%h have=%0h instr=%h pc=%h want all 0",
                            mem_req_out, mem_addr_out, have_out, instr_out, instr_pc_out);
        end
        tick();
        rst_in = 1'b0;
        tick();
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0 || have_out !== 1'b0) begin
            bad++; $display("FAIL post_reset_miss got req=%0h addr=%h have=%0h want 1/0/0", mem_req_out, mem_addr_out, have_out);
        end
    endtask

    task automatic test_pc_wrap();
        bit          found;
        logic [31:0] got;
        serve(found, got);
        total++; if (!found || got !== 32'h0) begin
            bad++; $display("FAIL wrap_fill0 got found=%0d addr=%h want 0", found, got);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        serve(found, got);
        total++; if (!found || got !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_fill got found=%0d addr=%h want fffffffc", found, got);
        end
        tick();
        total++; if (have_out !== 1'b1 || instr_pc_out !== 32'hFFFF_FFFC || instr_out !== exp_instr(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_top got have=%0h pc=%h instr=%h want 1/fffffffc", have_out, instr_pc_out, instr_out);
        end
        tick();
        total++; if (have_out !== 1'b1 || instr_pc_out !== 32'h0 || instr_out !== 32'h13 || mem_req_out !== 1'b0) begin
            bad++; $display("FAIL wrap_zero got have=%0h pc=%h instr=%h req=%0h want 1/0/13/0",
                            have_out, instr_pc_out, instr_out, mem_req_out);
        end
    endtask

    initial begin
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        if_not_full    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_done_in    = 1'b0;
        mem_data_in    = 32'h0;

        test_reset();
        test_cold_start();
        test_hit_stream();
        test_backpressure();
        test_redirect_in_miss();
        test_conflict();
        test_rdy_and_reset();
        test_pc_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
